// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline stages: the classification
// FSM encoding and the marker values written into the edge frames.
package canny_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MAX_SCAN = 2'd1,
    ST_THRESH   = 2'd2,
    ST_CLASSIFY = 2'd3
  } state_e;

  // Marker values written into the strong and weak edge frames
  localparam logic [7:0] STRONG_VAL = 8'd255;
  localparam logic [7:0] WEAK_VAL   = 8'd128;

  // Fractional width of the Q0.8 threshold ratios
  localparam int RATIO_W = 8;

endpackage

// File: rtl/dual_thr_calc.sv
// Combinational threshold derivation: hi = (max * HI_RATIO) >> 8 and
// lo = (hi * LO_RATIO) >> 8, both truncated and then clamped to at least 1
// so that an all-zero frame never classifies background as an edge.
module dual_thr_calc
  import canny_pkg::*;
#(
  parameter int P        = 8,
  parameter int HI_RATIO = 179,
  parameter int LO_RATIO = 128
) (
  input  logic [P-1:0] max_i,
  output logic [P-1:0] hi_o,
  output logic [P-1:0] lo_o
);

  localparam int PW = P + RATIO_W;

  function automatic logic [P-1:0] clamp_min1(input logic [P-1:0] v);
    return (v == '0) ? P'(1) : v;
  endfunction

  logic [PW-1:0] hi_prod;
  logic [PW-1:0] lo_prod;
  logic [P-1:0]  hi_val;

  // Scale the frame maximum down to the high threshold, then the high down to the low
  always_comb begin
    hi_prod = PW'(max_i) * PW'(HI_RATIO);
    hi_val  = clamp_min1(P'(hi_prod >> RATIO_W));
    lo_prod = PW'(hi_val) * PW'(LO_RATIO);
    hi_o    = hi_val;
    lo_o    = clamp_min1(P'(lo_prod >> RATIO_W));
  end

endmodule

// File: rtl/dual_threshold.sv
// Double-threshold stage of the Canny pipeline. One accepted frame is scanned
// twice: the first raster pass finds the frame maximum, a single cycle turns
// it into high/low thresholds, and the second pass marks each pixel strong,
// weak or background. dual_val pulses with the last pixel write.
module dual_threshold
  import canny_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PIX_WIDTH    = 24,
  parameter int HI_RATIO     = 179,
  parameter int LO_RATIO     = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   nms_val,
  input  logic [PIX_WIDTH/3-1:0] nms_pix   [FRAME_HEIGHT][FRAME_WIDTH],
  output logic                   busy,
  output logic [PIX_WIDTH/3-1:0] thr_hi,
  output logic [PIX_WIDTH/3-1:0] thr_lo,
  output logic                   dual_val,
  output logic [PIX_WIDTH/3-1:0] str_edge  [FRAME_HEIGHT][FRAME_WIDTH],
  output logic [PIX_WIDTH/3-1:0] weak_edge [FRAME_HEIGHT][FRAME_WIDTH]
);

  localparam int P  = PIX_WIDTH / 3;
  localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [P-1:0]  max_q, max_d;
  logic [P-1:0]  thr_hi_q, thr_lo_q;
  logic          dual_val_q, dual_val_d;
  logic [P-1:0]  str_q  [FRAME_HEIGHT][FRAME_WIDTH];
  logic [P-1:0]  weak_q [FRAME_HEIGHT][FRAME_WIDTH];

  logic [P-1:0]  pix_cur;
  logic          last_px;
  logic          scanning;
  logic [P-1:0]  calc_hi, calc_lo;

  assign pix_cur  = nms_pix[y_q][x_q];
  assign last_px  = (x_q == XW'(FRAME_WIDTH - 1)) && (y_q == YW'(FRAME_HEIGHT - 1));
  assign scanning = (state_q == ST_MAX_SCAN) || (state_q == ST_CLASSIFY);

  dual_thr_calc #(
    .P        (P),
    .HI_RATIO (HI_RATIO),
    .LO_RATIO (LO_RATIO)
  ) u_calc (
    .max_i (max_q),
    .hi_o  (calc_hi),
    .lo_o  (calc_lo)
  );

  // Next state: new frames are only accepted from IDLE, so a busy stage ignores nms_val
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (nms_val) state_d = ST_MAX_SCAN;
      ST_MAX_SCAN: if (last_px) state_d = ST_THRESH;
      ST_THRESH:   state_d = ST_CLASSIFY;
      ST_CLASSIFY: if (last_px) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Raster counters advance only while scanning and restart on every state change
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (scanning && (state_d == state_q)) begin
      if (x_q == XW'(FRAME_WIDTH - 1)) begin
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
        y_d = y_q;
      end
    end
  end

  // Running maximum, restarted when a frame is accepted
  always_comb begin
    max_d = max_q;
    if ((state_q == ST_IDLE) && (state_d == ST_MAX_SCAN)) begin
      max_d = '0;
    end else if ((state_q == ST_MAX_SCAN) && (pix_cur > max_q)) begin
      max_d = pix_cur;
    end
  end

  assign dual_val_d = (state_q == ST_CLASSIFY) && last_px;

  // Control, counter, maximum and threshold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      max_q      <= '0;
      thr_hi_q   <= '0;
      thr_lo_q   <= '0;
      dual_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      max_q      <= max_d;
      dual_val_q <= dual_val_d;
      if (state_q == ST_THRESH) begin
        thr_hi_q <= calc_hi;
        thr_lo_q <= calc_lo;
      end
    end
  end

  // Edge frames: one pixel classified per CLASSIFY cycle; strong and weak are exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < FRAME_HEIGHT; r++) begin
        for (int c = 0; c < FRAME_WIDTH; c++) begin
          str_q[r][c]  <= '0;
          weak_q[r][c] <= '0;
        end
      end
    end else if (state_q == ST_CLASSIFY) begin
      str_q[y_q][x_q]  <= (pix_cur >= thr_hi_q) ? P'(STRONG_VAL) : '0;
      weak_q[y_q][x_q] <= ((pix_cur < thr_hi_q) && (pix_cur >= thr_lo_q)) ? P'(WEAK_VAL) : '0;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign thr_hi    = thr_hi_q;
  assign thr_lo    = thr_lo_q;
  assign dual_val  = dual_val_q;
  assign str_edge  = str_q;
  assign weak_edge = weak_q;

endmodule

// File: tb/tb_dual_threshold.sv
// Directed + randomized bench for dual_threshold on a 4x4 frame. Expected
// thresholds and edge maps come from a plain-arithmetic reference model.
module tb_dual_threshold;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WH = W * H;

  logic       clk;
  logic       rst_n;
  logic       nms_val;
  logic [7:0] pix       [H][W];
  logic       busy;
  logic [7:0] thr_hi;
  logic [7:0] thr_lo;
  logic       dual_val;
  logic [7:0] str_edge  [H][W];
  logic [7:0] weak_edge [H][W];

  int checks = 0;
  int errors = 0;

  int exp_hi, exp_lo;
  int exp_str  [H][W];
  int exp_weak [H][W];

  dual_threshold #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H),
    .PIX_WIDTH    (24),
    .HI_RATIO     (179),
    .LO_RATIO     (128)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nms_val   (nms_val),
    .nms_pix   (pix),
    .busy      (busy),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .dual_val  (dual_val),
    .str_edge  (str_edge),
    .weak_edge (weak_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: thresholds from the frame maximum, then per-pixel class
  task automatic model();
    int mx;
    mx = 0;
    foreach (pix[r, c]) if (int'(pix[r][c]) > mx) mx = int'(pix[r][c]);
    exp_hi = (mx * 179) / 256;
    if (exp_hi < 1) exp_hi = 1;
    exp_lo = (exp_hi * 128) / 256;
    if (exp_lo < 1) exp_lo = 1;
    foreach (pix[r, c]) begin
      exp_str[r][c]  = (int'(pix[r][c]) >= exp_hi) ? 255 : 0;
      exp_weak[r][c] = (int'(pix[r][c]) < exp_hi && int'(pix[r][c]) >= exp_lo) ? 128 : 0;
    end
  endtask

  task automatic check_frame(input string tag);
    chk($sformatf("%s_thr_hi", tag), int'(thr_hi), exp_hi);
    chk($sformatf("%s_thr_lo", tag), int'(thr_lo), exp_lo);
    foreach (pix[r, c]) begin
      chk($sformatf("%s_str[%0d][%0d]", tag, r, c), int'(str_edge[r][c]), exp_str[r][c]);
      chk($sformatf("%s_weak[%0d][%0d]", tag, r, c), int'(weak_edge[r][c]), exp_weak[r][c]);
      chk($sformatf("%s_excl[%0d][%0d]", tag, r, c),
          int'(str_edge[r][c] != 0 && weak_edge[r][c] != 0), 0);
    end
    chk($sformatf("%s_busy_after", tag), int'(busy), 0);
  endtask

  function automatic int nonzero_cells();
    int n;
    n = 0;
    foreach (str_edge[r, c]) if (str_edge[r][c] != 0 || weak_edge[r][c] != 0) n++;
    return n;
  endfunction

  // Acceptance: nms_val is sampled high on edge E0; returns just after E0
  task automatic start_frame();
    @(negedge clk);
    nms_val = 1'b1;
    @(posedge clk);
    #1 nms_val = 1'b0;
  endtask

  // Watch ncyc edges after E0; nms_val is driven high for edges <= hold_until and at p1/p2
  task automatic watch(input int ncyc, input int hold_until, input int p1, input int p2,
                       output int first, output int second, output int npulse);
    first = -1; second = -1; npulse = 0;
    nms_val = (hold_until >= 1) || (p1 == 1) || (p2 == 1);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dual_val) begin
        npulse++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      nms_val = (k + 1 <= hold_until) || (k + 1 == p1) || (k + 1 == p2);
    end
    nms_val = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    int f, s, n;
    model();
    start_frame();
    watch(40, 0, 0, 0, f, s, n);
    chk($sformatf("%s_dual_at", tag), f, 2 * WH + 1);
    chk($sformatf("%s_dual_cnt", tag), n, 1);
    check_frame(tag);
  endtask

  initial begin
    int f, s, n;
    rst_n   = 1'b0;
    nms_val = 1'b0;
    foreach (pix[r, c]) pix[r][c] = 8'd0;

    // Reset with nms_val low: everything zero and stays zero
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cells", nonzero_cells(), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("idle_quiet_%0d", k),
          int'(busy) + int'(dual_val) + int'(thr_hi) + int'(thr_lo) + nonzero_cells(), 0);
    end

    // Ramp frame 0,16,...,240
    foreach (pix[r, c]) pix[r][c] = 8'((r * W + c) * 16);
    run_frame("ramp");
    chk("ramp_hi_const", int'(thr_hi), 167);
    chk("ramp_lo_const", int'(thr_lo), 83);

    // All-zero frame: thresholds clamp to 1
    foreach (pix[r, c]) pix[r][c] = 8'd0;
    run_frame("zero");
    chk("zero_hi_const", int'(thr_hi), 1);
    chk("zero_lo_const", int'(thr_lo), 1);

    // All-255 frame
    foreach (pix[r, c]) pix[r][c] = 8'd255;
    run_frame("full");
    chk("full_hi_const", int'(thr_hi), 178);
    chk("full_lo_const", int'(thr_lo), 89);

    // Randomized frames
    for (int t = 0; t < 4; t++) begin
      foreach (pix[r, c]) pix[r][c] = 8'($urandom_range(0, 255));
      run_frame($sformatf("rand%0d", t));
    end

    // Extra nms_val pulses while busy are ignored
    foreach (pix[r, c]) pix[r][c] = 8'($urandom_range(0, 200));
    model();
    start_frame();
    watch(80, 0, 5, 20, f, s, n);
    chk("pulse_dual_at", f, 2 * WH + 1);
    chk("pulse_dual_cnt", n, 1);
    check_frame("pulse");

    // nms_val held high: back-to-back frames
    foreach (pix[r, c]) pix[r][c] = 8'($urandom_range(0, 255));
    model();
    start_frame();
    watch(80, 2 * (2 * WH + 1) + 1, 0, 0, f, s, n);
    chk("held_dual1_at", f, 2 * WH + 1);
    chk("held_dual2_at", s, 2 * (2 * WH + 1) + 1);
    chk("held_dual_cnt", n, 2);
    check_frame("held");

    // Reset asserted during CLASSIFY at E0+25
    foreach (pix[r, c]) pix[r][c] = 8'($urandom_range(0, 255));
    start_frame();
    repeat (24) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cells", nonzero_cells(), 0);
    chk("mid_rst_thr", int'(thr_hi) + int'(thr_lo), 0);
    n = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (dual_val) n++;
    end
    rst_n = 1'b1;
    watch(40, 0, 0, 0, f, s, s);
    chk("mid_no_dual", n + s, 0);

    // Next frame completes normally after the interrupted one
    foreach (pix[r, c]) pix[r][c] = 8'($urandom_range(0, 255));
    run_frame("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_threshold.md
# dual_threshold

Double-threshold classification stage of the Canny edge pipeline, sitting between non-maximum suppression and hysteresis edge tracking. On a one-cycle `nms_val`, it scans the thinned magnitude frame twice. The first pass finds the frame maximum and derives the high and low thresholds from it. The second pass writes the strong-edge and weak-edge frames and then pulses `dual_val` to start the hysteresis stage.

## Interface
- `FRAME_WIDTH`, 640, frame width in pixels
- `FRAME_HEIGHT`, 480, frame height in pixels
- `PIX_WIDTH`, 24, RGB pixel width; per-pixel width is P = PIX_WIDTH/3 (8)
- `HI_RATIO`, 179, high threshold ratio in Q0.8 (0.70 of frame max)
- `LO_RATIO`, 128, low threshold ratio in Q0.8 (0.50 of high threshold)

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active low
- `nms_val`  in  1  NMS frame valid; sampled only in IDLE
- `nms_pix`  in  P × [FRAME_HEIGHT][FRAME_WIDTH]  suppressed gradient magnitude frame
- `busy`  out  1  high whenever state ≠ IDLE
- `thr_hi`  out  P  registered high threshold of the current/last frame
- `thr_lo`  out  P  registered low threshold of the current/last frame
- `dual_val`  out  1  one-cycle pulse; the frame outputs are complete
- `str_edge`  out  P × [FRAME_HEIGHT][FRAME_WIDTH]  255 where strong, else 0
- `weak_edge`  out  P × [FRAME_HEIGHT][FRAME_WIDTH]  128 where weak, else 0

## Operation
- State machine: IDLE, MAX_SCAN, THRESH, CLASSIFY.
  - IDLE → MAX_SCAN when `nms_val` = 1.
  - MAX_SCAN → THRESH after the last pixel (x = W-1, y = H-1).
  - THRESH → CLASSIFY unconditionally.
  - CLASSIFY → IDLE after the last pixel.
  - Illegal state → IDLE.
- Raster counters `x` (0..W-1) and `y` (0..H-1):
  - `x` wraps to 0 at W-1 and `y` increments on that wrap.
  - Both clear on every state change.
  - Both are held at 0 outside MAX_SCAN and CLASSIFY.
- MAX_SCAN: running max register, cleared on entry; max ← max(max, `nms_pix[y][x]`) once per cycle.
- THRESH, one cycle:
  - hi = (max × HI_RATIO) >> 8, using a 16-bit product, truncated.
  - lo = (hi × LO_RATIO) >> 8.
  - Each of hi and lo is clamped to a minimum of 1.
  - Results are registered into `thr_hi` and `thr_lo`.
- CLASSIFY, one pixel per cycle, with p = `nms_pix[y][x]`:
  - p ≥ hi: `str_edge` = 255, `weak_edge` = 0.
  - lo ≤ p < hi: `str_edge` = 0, `weak_edge` = 128.
  - p < lo: both 0.
  - A pixel is never marked both strong and weak.
- `nms_val` is ignored while `busy` = 1. No queueing and no second pulse.
- `nms_pix` must be held stable from acceptance until `dual_val`. The source owns that guarantee.
- Outputs hold their values until the next CLASSIFY overwrites them, pixel by pixel.

## Timing
- Acceptance edge E0 (IDLE, `nms_val` = 1): state becomes MAX_SCAN.
- MAX_SCAN pixels are consumed on edges E0+1 … E0+WH.
- THRESH registers the thresholds on edge E0+WH+1.
- CLASSIFY writes on edges E0+WH+2 … E0+2WH+1.
- `dual_val` rises on E0+2WH+1, the same edge as the last pixel write, and falls on E0+2WH+2.
- State is IDLE after E0+2WH+1. A `nms_val` held high is accepted on E0+2WH+2, giving back-to-back frames.
- Reset values: state IDLE, `busy` 0, `dual_val` 0, `thr_hi`/`thr_lo` 0, all `str_edge`/`weak_edge` elements 0, counters and max 0.
- Reset mid-operation: everything returns to its reset value immediately and no `dual_val` is produced.

## Structure
- Package `canny_pkg` holds:
  - state enum
  - STRONG_VAL = 255, WEAK_VAL = 128
  - Q0.8 ratio width constant
- These constants are shared with `hyst_threshold` consumers.
- Sub-module `dual_thr_calc`: combinational max→(hi, lo) arithmetic with clamping, so it can be unit-tested standalone.

## Test plan
Benches use FRAME_WIDTH = FRAME_HEIGHT = 4 and default ratios.

- Reset with `nms_val` low:
  - all outputs are 0 and stay 0 for 50 cycles.
- Ramp frame, values 0,16,…,240 in raster order:
  - `thr_hi` = 167, `thr_lo` = 83.
  - 176–240 → `str_edge` 255.
  - 96–160 → `weak_edge` 128.
  - 0–80 → both 0.
  - `dual_val` is high only after E0+33.
- All-zero frame:
  - thresholds clamp to 1/1.
  - all outputs are 0.
  - `dual_val` still pulses at E0+33.
- All-255 frame:
  - `thr_hi` = 178, `thr_lo` = 89.
  - every `str_edge` = 255, every `weak_edge` = 0.
- `nms_val` pulsed at E0+5 and E0+20:
  - exactly one `dual_val`.
- `nms_val` held high:
  - second frame accepted at E0+34.
  - second `dual_val` at E0+67.
- `rst_n` asserted during CLASSIFY (E0+25):
  - arrays are 0, `busy` is 0, no `dual_val`.
  - the next frame completes normally.
